// File: rtl/pe_config_loader_pkg.sv
// cgra_cfg_pkg: shared types, defaults and sizing helper for the PE config loader.
package cgra_cfg_pkg;
  localparam int CFG_WORD_W  = 32;
  localparam int CFG_CLR_CYC = 2;
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, SH_LO, SH_HI, FIN} cfg_ld_state_t;
  function automatic int words_per_chain(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/pe_config_loader_if.sv
// pe_config_loader_if: host-to-loader configuration word stream (valid/ready).
interface pe_config_loader_if
  import cgra_cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    modport master (output cfg_data, cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/pe_config_loader_serializer.sv
// cfg_bit_serializer: holds the latched config word and its bit index, presents bit idx LSB-first.
module cfg_bit_serializer
  import cgra_cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W,
    localparam int IW    = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              bit_o,
    output logic              word_end_o,
    output logic [IW-1:0]     idx_o
);
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shifted;
    logic [IW-1:0]     idx_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            idx_q   <= '0;
        end else if (clr_i) begin
            idx_q   <= '0;
        end else if (step_i) begin
            idx_q   <= idx_q + IW'(1);
        end
    end
    assign shifted    = shreg_q >> idx_q;
    assign bit_o      = shifted[0];
    // asserted while the last bit of the word is on the wire
    assign word_end_o = idx_q == IW'(WORD_W - 1);
    assign idx_o      = idx_q;
endmodule

// File: rtl/pe_config_loader.sv
// pe_config_loader: serialises host config words into a PE daisy chain with generated config_clk/config_reset.
// Optional tail readback is enabled by defining CFG_LOADER_READBACK_EN.
module pe_config_loader
  import cgra_cfg_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int CHAIN_LEN = 128,
    parameter int CLR_CYC   = CFG_CLR_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    pe_config_loader_if.slave   cfg,
    output logic                config_clk,
    output logic                config_reset,
    output logic                config_bit,
    input  logic                config_ret,
    output logic                busy,
    output logic                done
`ifdef CFG_LOADER_READBACK_EN
    ,
    output logic [WORD_W-1:0]   rb_data,
    output logic                rb_valid
`endif
);
    localparam int TW = $clog2(CHAIN_LEN + 1);
    localparam int CW = $clog2(CLR_CYC + 1);
    localparam int IW = $clog2(WORD_W + 1);
    cfg_ld_state_t state_q, state_d;
    logic [TW-1:0] tot_q, tot_d;
    logic [CW-1:0] clr_q, clr_d;
    logic          ser_bit, word_end, load, last_bit;
    logic [IW-1:0] idx;
    assign load     = state_q == WAIT && cfg.cfg_valid;
    assign last_bit = tot_q == TW'(CHAIN_LEN - 1);
    cfg_bit_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .clr_i      (state_q == CLEAR),
        .step_i     (state_q == SH_HI),
        .data_i     (cfg.cfg_data),
        .bit_o      (ser_bit),
        .word_end_o (word_end),
        .idx_o      (idx)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tot_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
            clr_q   <= clr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE: begin
                state_d = start ? CLEAR : IDLE;
                clr_d   = '0;
            end
            CLEAR: begin
                tot_d   = '0;
                clr_d   = clr_q + CW'(1);
                state_d = clr_q == CW'(CLR_CYC - 1) ? WAIT : CLEAR;
            end
            WAIT:  state_d = cfg.cfg_valid ? SH_LO : WAIT;
            SH_LO: state_d = SH_HI;
            SH_HI: begin
                tot_d   = tot_q + TW'(1);
                state_d = last_bit ? FIN : word_end ? WAIT : SH_LO;
            end
            default: state_d = IDLE;
        endcase
    end
    assign cfg.cfg_ready = state_q == WAIT;
    assign config_clk    = state_q == SH_HI;
    assign config_reset  = state_q == CLEAR;
    assign config_bit    = (state_q == SH_LO || state_q == SH_HI) && ser_bit;
    assign busy          = state_q != IDLE;
    assign done          = state_q == FIN;
`ifdef CFG_LOADER_READBACK_EN
    logic [WORD_W-1:0] rb_sh_q, rb_data_q;
    logic              rb_valid_q, rb_end;
    assign rb_end = state_q == SH_HI && (last_bit || word_end);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_sh_q    <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= rb_end;
            if (load) rb_sh_q <= '0;
            else if (state_q == SH_LO) rb_sh_q <= rb_sh_q | (WORD_W'(config_ret) << idx);
            if (rb_end) rb_data_q <= rb_sh_q;
        end
    end
    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_ret;
    assign unused_ret = config_ret ^ (|idx);
`endif
endmodule
